// File: rtl/shift_seq_pkg.sv
// ---------------------------------------------------------------------------
// shift_seq_pkg
//   Shared types and default sizing for the multi-cycle shift sequencer.
//   - seq_state_t : sequencer FSM states (IDLE, SHIFT, FINISH)
//   - SEQ_WIDTH   : default data width
//   - SEQ_CNT_W   : default shift-amount width (2**SEQ_CNT_W <= SEQ_WIDTH)
// ---------------------------------------------------------------------------
package shift_seq_pkg;

    localparam int SEQ_WIDTH = 32;
    localparam int SEQ_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } seq_state_t;

endpackage : shift_seq_pkg

// File: rtl/shift_step.sv
// ---------------------------------------------------------------------------
// shift_step
//   One-position combinational shifter used inside the operand register loop.
//   Ports:
//     SHIFT_IN  [WIDTH] : operand before the step
//     RIGHT             : 1 = shift toward LSB, 0 = shift toward MSB
//     SHIFT             : 1 = perform the step, 0 = pass SHIFT_IN through
//     FILL              : bit inserted at the MSB on right shifts
//     SHIFT_OUT [WIDTH] : operand after the step
//   Left shifts always insert 0 at the LSB.
// ---------------------------------------------------------------------------
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH
) (
    input  logic [WIDTH-1:0] SHIFT_IN,
    input  logic             RIGHT,
    input  logic             SHIFT,
    input  logic             FILL,
    output logic [WIDTH-1:0] SHIFT_OUT
);

    always_comb begin
        SHIFT_OUT = SHIFT_IN;
        if (SHIFT) begin
            if (RIGHT) begin
                SHIFT_OUT = {FILL, SHIFT_IN[WIDTH-1:1]};
            end else begin
                SHIFT_OUT = {SHIFT_IN[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule : shift_step

// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//   Multi-cycle logical shifter for the DLX execute stage. Shifts DATA_IN by
//   AMOUNT positions (left or right), one position per clock, and reports
//   completion with a one-cycle DONE pulse. BUSY lets the execute control
//   stall the pipeline while a shift is in flight.
//
//   Optional feature (compile-time macro SHIFT_SEQ_ARITH_EN):
//     defined   -> ARITH port exists; right shifts with ARITH=1 sign-extend.
//     undefined -> no ARITH port; every right shift zero-fills.
//
//   Ports:
//     CLK               : clock, rising edge
//     RESET             : asynchronous, active-high reset
//     START             : request, only sampled while IDLE
//     DATA_IN  [WIDTH]  : operand, captured on START acceptance
//     AMOUNT   [CNT_W]  : shift distance, captured on START acceptance
//     RIGHT             : direction (1 = right), captured on START acceptance
//     ARITH             : sign-fill request (SHIFT_SEQ_ARITH_EN only)
//     BUSY              : high in SHIFT and FINISH
//     DONE              : one-cycle pulse in FINISH, result valid
//     DATA_OUT [WIDTH]  : operand register; stable outside SHIFT
//
//   Timing (START accepted in cycle 0): DONE in cycle AMOUNT+1, BUSY in
//   cycles 1..AMOUNT+1, next START accepted no earlier than AMOUNT+2.
//   CNT_W must satisfy 2**CNT_W <= WIDTH.
// ---------------------------------------------------------------------------
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH,
    parameter int CNT_W = SEQ_CNT_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic [CNT_W-1:0] AMOUNT,
    input  logic             RIGHT,
`ifdef SHIFT_SEQ_ARITH_EN
    input  logic             ARITH,
`endif
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] DATA_OUT
);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    seq_state_t       r_state;
    seq_state_t       w_next_state;

    logic [WIDTH-1:0] r_operand;
    logic [CNT_W-1:0] r_cnt;
    logic             r_right;

    // FSM decoded controls
    logic             w_load;   // accept START this cycle
    logic             w_step;   // advance operand one position this cycle
    logic             w_busy;
    logic             w_done;

    // Shifter interface
    logic             w_fill;
    logic [WIDTH-1:0] w_step_out;

    // -----------------------------------------------------------------------
    // Fill bit for right shifts
    // -----------------------------------------------------------------------
`ifdef SHIFT_SEQ_ARITH_EN
    logic r_arith;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_arith <= 1'b0;
        end else if (w_load) begin
            r_arith <= ARITH;
        end
    end

    // The step module only uses FILL on right shifts, so gating with
    // r_right is not strictly needed; it keeps the intent explicit.
    assign w_fill = r_arith & r_right & r_operand[WIDTH-1];
`else
    assign w_fill = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (START) begin
                    // A zero-distance shift still spends one cycle in
                    // FINISH so DONE timing is uniform (AMOUNT+1).
                    w_next_state = (AMOUNT == '0) ? FINISH : SHIFT;
                end
            end
            SHIFT: begin
                // r_cnt holds the steps still to perform, including the one
                // happening this cycle; the last step hands off to FINISH.
                if (r_cnt == CNT_W'(1)) begin
                    w_next_state = FINISH;
                end
            end
            FINISH: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: output decode
    // -----------------------------------------------------------------------
    always_comb begin
        w_load = 1'b0;
        w_step = 1'b0;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            IDLE: begin
                w_load = START;
            end
            SHIFT: begin
                w_step = 1'b1;
                w_busy = 1'b1;
            end
            FINISH: begin
                w_busy = 1'b1;
                w_done = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // One-position shifter in the operand register loop
    // -----------------------------------------------------------------------
    shift_step #(
        .WIDTH (WIDTH)
    ) u_shift_step (
        .SHIFT_IN  (r_operand),
        .RIGHT     (r_right),
        .SHIFT     (w_step),
        .FILL      (w_fill),
        .SHIFT_OUT (w_step_out)
    );

    // -----------------------------------------------------------------------
    // Operand register, step counter and direction latch
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_operand <= '0;
            r_cnt     <= '0;
            r_right   <= 1'b0;
        end else if (w_load) begin
            r_operand <= DATA_IN;
            r_cnt     <= AMOUNT;
            r_right   <= RIGHT;
        end else if (w_step) begin
            r_operand <= w_step_out;
            r_cnt     <= r_cnt - CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign BUSY     = w_busy;
    assign DONE     = w_done;
    assign DATA_OUT = r_operand;

endmodule : shift_sequencer

// File: tb/tb_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_sequencer
//   Directed self-checking bench for shift_sequencer. Inputs are driven and
//   outputs sampled on the falling clock edge. Cycle 0 is the cycle in which
//   START is presented to an IDLE sequencer.
// ---------------------------------------------------------------------------
module tb_shift_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [31:0] DATA_IN;
    logic [4:0]  AMOUNT;
    logic        RIGHT;
`ifdef SHIFT_SEQ_ARITH_EN
    logic        ARITH;
`endif
    logic        BUSY;
    logic        DONE;
    logic [31:0] DATA_OUT;

    int n_vec = 0;
    int n_err = 0;

    shift_sequencer #(
        .WIDTH (32),
        .CNT_W (5)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .START    (START),
        .DATA_IN  (DATA_IN),
        .AMOUNT   (AMOUNT),
        .RIGHT    (RIGHT),
`ifdef SHIFT_SEQ_ARITH_EN
        .ARITH    (ARITH),
`endif
        .BUSY     (BUSY),
        .DONE     (DONE),
        .DATA_OUT (DATA_OUT)
    );

    always #5 CLK = ~CLK;

    // -----------------------------------------------------------------------
    task automatic test_reset();
        RESET   = 1'b1;
        START   = 1'b0;
        DATA_IN = 32'hDEAD_BEEF;
        AMOUNT  = 5'd7;
        RIGHT   = 1'b0;
`ifdef SHIFT_SEQ_ARITH_EN
        ARITH   = 1'b0;
`endif
        @(negedge CLK);
        @(negedge CLK);
        n_vec++;
        if (BUSY !== 1'b0) begin
            n_err++; $display("FAIL reset_busy: got %b want 0", BUSY);
        end
        n_vec++;
        if (DONE !== 1'b0) begin
            n_err++; $display("FAIL reset_done: got %b want 0", DONE);
        end
        n_vec++;
        if (DATA_OUT !== 32'h0) begin
            n_err++; $display("FAIL reset_data: got %h want 00000000", DATA_OUT);
        end
        RESET = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    // One complete operation: checks DONE cycle, BUSY window, result, and the
    // idle cycle afterwards. Inputs are scrambled after acceptance since they
    // must not matter once the operation is running.
    task automatic test_shift(input string name, input logic [31:0] d,
                              input logic [4:0] amt, input logic r,
                              input logic a, input logic [31:0] exp);
        int done_cyc;
        int busy_bad;
        done_cyc = -1;
        busy_bad = 0;
        @(negedge CLK);
        DATA_IN = d;
        AMOUNT  = amt;
        RIGHT   = r;
`ifdef SHIFT_SEQ_ARITH_EN
        ARITH   = a;
`endif
        START   = 1'b1;
        @(negedge CLK);
        START   = 1'b0;
        DATA_IN = ~d;
        AMOUNT  = ~amt;
        RIGHT   = ~r;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (BUSY !== 1'b1) busy_bad++;
            if (DONE === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            @(negedge CLK);
        end
        n_vec++;
        if (done_cyc != int'(amt) + 1) begin
            n_err++;
            $display("FAIL %s done_cycle: got %0d want %0d (arith=%0b)",
                     name, done_cyc, int'(amt) + 1, a);
        end
        n_vec++;
        if (DATA_OUT !== exp) begin
            n_err++; $display("FAIL %s result: got %h want %h", name, DATA_OUT, exp);
        end
        n_vec++;
        if (busy_bad != 0) begin
            n_err++; $display("FAIL %s busy_window: %0d low cycles want 0", name, busy_bad);
        end
        @(negedge CLK);
        n_vec++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || DATA_OUT !== exp) begin
            n_err++;
            $display("FAIL %s idle_after: busy=%b done=%b data=%h want 0 0 %h",
                     name, BUSY, DONE, DATA_OUT, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // START held through a 3-step shift; DATA_IN changes mid-run. The first
    // result is 0xF<<3 = 0x78; the held START is taken in cycle 5 with
    // 0xFFFFFFFF, giving 0xFFFFFFF8 with DONE in cycle 9.
    task automatic test_back_to_back();
        int dones;
        dones = 0;
        @(negedge CLK);
        DATA_IN = 32'h0000_000F;
        AMOUNT  = 5'd3;
        RIGHT   = 1'b0;
`ifdef SHIFT_SEQ_ARITH_EN
        ARITH   = 1'b0;
`endif
        START   = 1'b1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge CLK);
            if (DONE === 1'b1) dones++;
            if (cyc == 2) DATA_IN = 32'hFFFF_FFFF;
            if (cyc == 4) begin
                n_vec++;
                if (DONE !== 1'b1 || DATA_OUT !== 32'h0000_0078) begin
                    n_err++;
                    $display("FAIL collision_first: done=%b data=%h want 1 00000078", DONE, DATA_OUT);
                end
            end
            if (cyc == 5) begin
                n_vec++;
                if (BUSY !== 1'b0 || DATA_OUT !== 32'h0000_0078) begin
                    n_err++;
                    $display("FAIL collision_idle: busy=%b data=%h want 0 00000078", BUSY, DATA_OUT);
                end
            end
            if (cyc == 6) begin
                n_vec++;
                if (BUSY !== 1'b1) begin
                    n_err++; $display("FAIL collision_second_accept: busy=%b want 1", BUSY);
                end
                START = 1'b0;
            end
            if (cyc == 9) begin
                n_vec++;
                if (DONE !== 1'b1 || DATA_OUT !== 32'hFFFF_FFF8) begin
                    n_err++;
                    $display("FAIL collision_second: done=%b data=%h want 1 fffffff8", DONE, DATA_OUT);
                end
            end
        end
        n_vec++;
        if (dones != 2) begin
            n_err++; $display("FAIL collision_done_count: got %0d want 2", dones);
        end
    endtask

    // -----------------------------------------------------------------------
    // RESET in cycle 2 of an AMOUNT=10 shift, then a fresh 0x3<<2 operation
    // started as RESET drops: only its DONE (cycle 3, 0xC) may appear.
    task automatic test_reset_mid_op();
        int dones;
        int done_at;
        dones   = 0;
        done_at = -1;
        @(negedge CLK);
        DATA_IN = 32'h0000_0ABC;
        AMOUNT  = 5'd10;
        RIGHT   = 1'b0;
        START   = 1'b1;
        @(negedge CLK);
        START   = 1'b0;
        @(negedge CLK);
        RESET   = 1'b1;
        #1;
        n_vec++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || DATA_OUT !== 32'h0) begin
            n_err++;
            $display("FAIL midreset_clear: busy=%b done=%b data=%h want 0 0 00000000",
                     BUSY, DONE, DATA_OUT);
        end
        @(negedge CLK);
        RESET   = 1'b0;
        DATA_IN = 32'h0000_0003;
        AMOUNT  = 5'd2;
        RIGHT   = 1'b0;
        START   = 1'b1;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            @(negedge CLK);
            START = 1'b0;
            if (cyc == 1) begin
                n_vec++;
                if (BUSY !== 1'b1) begin
                    n_err++; $display("FAIL midreset_restart_busy: got %b want 1", BUSY);
                end
            end
            if (DONE === 1'b1) begin
                dones++;
                if (done_at < 0) done_at = cyc;
                if (cyc == 3) begin
                    n_vec++;
                    if (DATA_OUT !== 32'h0000_000C) begin
                        n_err++; $display("FAIL midreset_result: got %h want 0000000c", DATA_OUT);
                    end
                end
            end
        end
        n_vec++;
        if (dones != 1 || done_at != 3) begin
            n_err++;
            $display("FAIL midreset_dones: count=%0d first=%0d want 1 at 3", dones, done_at);
        end
    endtask

    // -----------------------------------------------------------------------
    initial begin
        test_reset();
        test_shift("left4", 32'h8000_0001, 5'd4, 1'b0, 1'b0, 32'h0000_0010);
`ifdef SHIFT_SEQ_ARITH_EN
        test_shift("right31_logical", 32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'h0000_0001);
        test_shift("right31_arith", 32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF);
        test_shift("right4_arith", 32'hF000_0000, 5'd4, 1'b1, 1'b1, 32'hFF00_0000);
`else
        test_shift("right31", 32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'h0000_0001);
        test_shift("right4_arith_req", 32'hF000_0000, 5'd4, 1'b1, 1'b1, 32'h0F00_0000);
`endif
        test_shift("zero_amount", 32'h1234_5678, 5'd0, 1'b0, 1'b0, 32'h1234_5678);
        test_shift("left31_arith_ignored", 32'h0000_0001, 5'd31, 1'b0, 1'b1, 32'h8000_0000);
        test_shift("right1_positive", 32'h7FFF_FFFF, 5'd1, 1'b1, 1'b1, 32'h3FFF_FFFF);
        test_back_to_back();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_shift_sequencer
